mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-port synchronous memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the multi-cycle core. Both requesters sit beside the control unit: IF is driven during FETCH and LS during MEMORY. The arbiter serialises their accesses, grants alternately when they contend, and returns read data with a one-cycle valid pulse. Fetch grants are suppressed once the control unit reports the program halted.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal 1..15)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- fetch_en  in  1  connect to program_running; 0 masks if_req
- if_req  in  1  fetch request; if_addr held stable until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle grant pulse
- if_rvalid  out  1  one-cycle read-data valid pulse
- if_rdata  out  DW  fetched word, valid with if_rvalid
- ls_req  in  1  load/store request; ls_we/ls_addr/ls_wdata held stable until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  one-cycle grant pulse
- ls_rvalid  out  1  one-cycle load-data valid pulse (never for stores)
- ls_rdata  out  DW  load data, valid with ls_rvalid
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  1 whenever state != IDLE

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- Arbitration happens only in IDLE and RESP. Effective requests are ifr = if_req & fetch_en and lsr = ls_req.
  - Only one effective request: that requester wins.
  - Both: the requester that was not last_owner wins.
  - last_owner resets to LS, so IF wins the first contention.
- On a win, the arbiter latches addr/we/wdata (we = 0 for IF) and the owner, and updates last_owner. Next state is ACCESS.
- ACCESS (1 cycle): mem_en = 1, mem_we/mem_addr/mem_wdata from the latched copy, owner's gnt = 1.
  - Store: next state IDLE.
  - Read: next state WAIT.
- WAIT: counter counts MEM_LAT cycles. On the last WAIT cycle edge, mem_rdata is captured into the owner's rdata register. Next state RESP.
- RESP (1 cycle): owner's rvalid = 1. Arbitration runs in the same cycle.
- A requester must drop req in the cycle after gnt unless it is issuing a new request. A req still high in IDLE/RESP counts as a new request.
- if_rdata and ls_rdata hold their last captured value until the next capture for that port.
- fetch_en = 0 only masks arbitration. An IF access already past arbitration completes normally.
- Reset (rst = 0 at an edge):
  - State IDLE, last_owner LS, counter 0.
  - All outputs 0, including rdata registers.
  - An in-flight access is abandoned: no rvalid, mem_en low from the next cycle.
  - Memory responses arriving after reset are ignored.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Read, request first seen in cycle 0:
  - gnt and mem_en in cycle 1
  - mem_rdata sampled at the end of cycle 1+MEM_LAT
  - rvalid in cycle 2+MEM_LAT
  - Read latency is MEM_LAT+2 cycles.
- Back-to-back reads: the next ACCESS is in cycle 3+MEM_LAT, so one read per MEM_LAT+2 cycles.
- Store: gnt and mem_en in cycle 1, IDLE in cycle 2, next ACCESS no earlier than cycle 3. One store per 2 cycles.
- gnt, rvalid and mem_en are each high for exactly one cycle per access. if_* and ls_* strobes are never high in the same cycle.

## Test plan
- Reset: hold rst = 0 for 3 cycles with if_req = ls_req = 1. Required: all outputs 0, busy = 0. After release, IF is granted first.
- Single fetch, MEM_LAT = 1: if_addr = 0x10 in cycle 0, memory returns 0xDEADBEEF. Required: if_gnt and mem_en in cycle 1 with mem_addr = 0x10, mem_we = 0; if_rvalid in cycle 3 with if_rdata = 0xDEADBEEF.
- Contention: if_req and ls_req (load 0x40) held continuously. Required: grant sequence IF, LS, IF, LS with no cycle where both gnt are high.
- Store: ls_we = 1, ls_addr = 0x80, ls_wdata = 0x12345678. Required: mem_we = 1 with those values in cycle 1; no ls_rvalid; busy = 0 in cycle 2.
- Halt: fetch_en = 0 with if_req = 1. Required: no if_gnt; a concurrent load is still served. Raise fetch_en: IF is granted in the next arbitration cycle.
- Reset mid-read, MEM_LAT = 4: assert rst in cycle 3. Required: no rvalid; state IDLE; the late mem_rdata is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Requester, response and memory signals of the IF/LS memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          fetch_en;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        output fetch_en, if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );

    modport slave (
        input  fetch_en, if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Serialises IF and LS accesses onto one single-port synchronous memory
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t        state;
    logic          last_ls;
    logic          owner_ls;
    logic [3:0]    cnt;

    logic          pick_if;
    logic          pick_ls;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // IF wins a contention unless it owned the previous access
    always_comb begin
        pick_if   = bus.if_req & bus.fetch_en & (~bus.ls_req | last_ls);
        pick_ls   = bus.ls_req & ~pick_if;
        win_we    = pick_ls & bus.ls_we;
        win_addr  = pick_ls ? bus.ls_addr : bus.if_addr;
        win_wdata = pick_ls ? bus.ls_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last_ls       <= 1'b1;
            owner_ls      <= 1'b0;
            cnt           <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_gnt    <= 1'b0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_rdata  <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.if_gnt    <= 1'b0;
            bus.ls_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.ls_rvalid <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (pick_if || pick_ls) begin
                        state         <= ACCESS;
                        bus.busy      <= 1'b1;
                        owner_ls      <= pick_ls;
                        last_ls       <= pick_ls;
                        bus.if_gnt    <= pick_if;
                        bus.ls_gnt    <= pick_ls;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= win_we;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    cnt <= '0;
                    // mem_we is only high during a store's ACCESS cycle
                    if (bus.mem_we) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= RESP;
                        if (owner_ls) begin
                            bus.ls_rdata  <= bus.mem_rdata;
                            bus.ls_rvalid <= 1'b1;
                        end else begin
                            bus.if_rdata  <= bus.mem_rdata;
                            bus.if_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
